// File: rtl/mapache64_pkg.sv
// rtl/mapache64_pkg.sv - shared types and constants for the mapache64 video/DMA blocks
package mapache64;

  typedef logic [7:0]  data_t;
  typedef logic [11:0] vram_address_t;

  typedef enum logic {
    TGT_OBM = 1'b0,
    TGT_PMF = 1'b1
  } dma_target_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    XFER   = 2'd2,
    FINISH = 2'd3
  } dma_state_t;

  localparam vram_address_t OBM_BASE = 12'h800;
  localparam vram_address_t PMF_BASE = 12'h000;

  localparam int OBM_BYTES_DEFAULT = 256;
  localparam int PMF_BYTES_DEFAULT = 512;

endpackage

// File: rtl/obm_dma.sv
// rtl/obm_dma.sv - work-RAM page to VRAM (OBM or PMF) copy engine
module obm_dma
  import mapache64::*;
#(
  parameter int OBM_BYTES = OBM_BYTES_DEFAULT,
  parameter int PMF_BYTES = PMF_BYTES_DEFAULT
) (
  input  logic          cpu_clk,
  input  logic          rst,
  input  logic          start_i,
  input  dma_target_t   target_i,
  input  logic [7:0]    page_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [15:0]   src_address_o,
  output logic          src_ren_o,
  input  data_t         src_rdata_i,
  output data_t         vram_wdata_o,
  output vram_address_t vram_address_o,
  output logic          vram_wen_o,
  output logic          SELECT_obm_o,
  output logic          SELECT_pmf_o
);

  localparam int MAX_BYTES = (OBM_BYTES > PMF_BYTES) ? OBM_BYTES : PMF_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t OBM_LAST = cnt_t'(OBM_BYTES - 1);
  localparam cnt_t PMF_LAST = cnt_t'(PMF_BYTES - 1);

  dma_state_t    state, state_nxt;
  dma_target_t   tgt_q, tgt_nxt;
  logic [7:0]    page_q, page_nxt;
  cnt_t          cnt_q, cnt_nxt;
  cnt_t          last;

  logic          busy_nxt, done_nxt, src_ren_nxt, wen_nxt, sel_obm_nxt, sel_pmf_nxt;
  logic [15:0]   src_addr_nxt;
  vram_address_t vaddr_nxt;
  logic          wen_q, sel_obm_q, sel_pmf_q;

  assign last = (tgt_q == TGT_OBM) ? OBM_LAST : PMF_LAST;

  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      tgt_q          <= TGT_OBM;
      page_q         <= '0;
      cnt_q          <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      src_ren_o      <= 1'b0;
      src_address_o  <= '0;
      vram_address_o <= '0;
      wen_q          <= 1'b0;
      sel_obm_q      <= 1'b0;
      sel_pmf_q      <= 1'b0;
    end else begin
      state          <= state_nxt;
      tgt_q          <= tgt_nxt;
      page_q         <= page_nxt;
      cnt_q          <= cnt_nxt;
      busy_o         <= busy_nxt;
      done_o         <= done_nxt;
      src_ren_o      <= src_ren_nxt;
      src_address_o  <= src_addr_nxt;
      vram_address_o <= vaddr_nxt;
      wen_q          <= wen_nxt;
      sel_obm_q      <= sel_obm_nxt;
      sel_pmf_q      <= sel_pmf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt_q;
    page_nxt  = page_q;
    cnt_nxt   = cnt_q;
    unique case (state)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_nxt = PRIME;
          tgt_nxt   = target_i;
          page_nxt  = page_i;
          cnt_nxt   = '0;
        end
      end
      PRIME: state_nxt = abort_i ? IDLE : XFER;
      XFER: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (cnt_q == last) begin
          state_nxt = FINISH;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    src_ren_nxt  = 1'b0;
    wen_nxt      = 1'b0;
    sel_obm_nxt  = 1'b0;
    sel_pmf_nxt  = 1'b0;
    src_addr_nxt = '0;
    vaddr_nxt    = '0;
    unique case (state_nxt)
      PRIME: begin
        busy_nxt     = 1'b1;
        src_ren_nxt  = 1'b1;
        src_addr_nxt = {page_nxt, 8'h00};
      end
      XFER: begin
        busy_nxt     = 1'b1;
        wen_nxt      = 1'b1;
        sel_obm_nxt  = (tgt_nxt == TGT_OBM);
        sel_pmf_nxt  = (tgt_nxt == TGT_PMF);
        vaddr_nxt    = ((tgt_nxt == TGT_OBM) ? OBM_BASE : PMF_BASE) + vram_address_t'(cnt_nxt);
        src_ren_nxt  = (cnt_nxt != last);
        src_addr_nxt = {page_nxt, 8'h00} + 16'(cnt_nxt) + 16'd1;
      end
      FINISH:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  // An abort must suppress the write of the very cycle it is raised in.
  assign vram_wen_o   = wen_q & ~abort_i;
  assign SELECT_obm_o = sel_obm_q & ~abort_i;
  assign SELECT_pmf_o = sel_pmf_q & ~abort_i;
  assign vram_wdata_o = src_rdata_i;

endmodule

// File: tb/tb_obm_dma.sv
// tb/tb_obm_dma.sv - self-checking bench for obm_dma
module tb_obm_dma;
  import mapache64::*;

  logic          cpu_clk = 1'b0;
  logic          rst;
  logic          start_i;
  dma_target_t   target_i;
  logic [7:0]    page_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   src_address_o;
  logic          src_ren_o;
  data_t         src_rdata_i;
  data_t         vram_wdata_o;
  vram_address_t vram_address_o;
  logic          vram_wen_o;
  logic          SELECT_obm_o;
  logic          SELECT_pmf_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 cpu_clk = ~cpu_clk;

  obm_dma dut (
    .cpu_clk        (cpu_clk),
    .rst            (rst),
    .start_i        (start_i),
    .target_i       (target_i),
    .page_i         (page_i),
    .abort_i        (abort_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .src_address_o  (src_address_o),
    .src_ren_o      (src_ren_o),
    .src_rdata_i    (src_rdata_i),
    .vram_wdata_o   (vram_wdata_o),
    .vram_address_o (vram_address_o),
    .vram_wen_o     (vram_wen_o),
    .SELECT_obm_o   (SELECT_obm_o),
    .SELECT_pmf_o   (SELECT_pmf_o)
  );

  // Work-RAM contents: page 02 holds k^5A; other pages differ so wrong pages show up.
  function automatic data_t ram_f(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] + 8'hFE);
  endfunction

  always @(posedge cpu_clk) src_rdata_i <= src_ren_o ? ram_f(src_address_o) : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  typedef struct {
    dma_target_t tgt;
    logic [7:0]  page;
    int          abort_k;   // -2 none, -1 in PRIME, else XFER cycle
    int          poke_k;    // -1 none, else XFER cycle with a stray start_i
    int          n_wr;
    int          n_busy;
    int          n_done;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    int nwr = 0, nbusy = 0, ndone = 0, addr_bad = 0, data_bad = 0, sel_bad = 0;
    bit ended = 1'b0;
    logic [15:0] src;
    logic [11:0] base;
    base = (v.tgt == TGT_OBM) ? 12'h800 : 12'h000;
    @(posedge cpu_clk); #1;
    start_i = 1'b1; target_i = v.tgt; page_i = v.page;
    @(posedge cpu_clk); #1;
    start_i = 1'b0; target_i = TGT_OBM; page_i = 8'h00;
    for (int cyc = 0; cyc < 1200 && !ended; cyc++) begin
      abort_i = (v.abort_k != -2) && (cyc == v.abort_k + 1);
      start_i = (v.poke_k >= 0) && (cyc == v.poke_k + 1);
      if (start_i) begin
        target_i = (v.tgt == TGT_OBM) ? TGT_PMF : TGT_OBM;
        page_i   = 8'h33;
      end
      @(negedge cpu_clk);
      if (busy_o) nbusy++;
      if (done_o) ndone++;
      if (vram_wen_o) begin
        src = {v.page, 8'h00} + 16'(nwr);
        if (vram_address_o !== base + 12'(nwr)) addr_bad++;
        if (vram_wdata_o !== ram_f(src)) data_bad++;
        if (SELECT_obm_o !== (v.tgt == TGT_OBM) || SELECT_pmf_o !== (v.tgt == TGT_PMF)) sel_bad++;
        nwr++;
      end
      if (cyc > 0 && !busy_o && !done_o) ended = 1'b1;
      if (!ended) begin
        @(posedge cpu_clk); #1;
      end
    end
    abort_i = 1'b0;
    start_i = 1'b0;
    chk($sformatf("v%0d ended", idx), 32'(ended), 32'd1);
    chk($sformatf("v%0d write_count", idx), 32'(nwr), 32'(v.n_wr));
    chk($sformatf("v%0d busy_cycles", idx), 32'(nbusy), 32'(v.n_busy));
    chk($sformatf("v%0d done_pulses", idx), 32'(ndone), 32'(v.n_done));
    chk($sformatf("v%0d bad_addresses", idx), 32'(addr_bad), 32'd0);
    chk($sformatf("v%0d bad_data", idx), 32'(data_bad), 32'd0);
    chk($sformatf("v%0d bad_select", idx), 32'(sel_bad), 32'd0);
    chk($sformatf("v%0d idle_strobes", idx),
        32'({src_ren_o, vram_wen_o, SELECT_obm_o, SELECT_pmf_o}), 32'd0);
    chk($sformatf("v%0d idle_addresses", idx), {4'h0, vram_address_o, src_address_o}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    int nwr, ndone, seen, d1, d2;

    vecs[0] = '{TGT_OBM, 8'h02, -2, -1, 256, 257, 1};
    vecs[1] = '{TGT_PMF, 8'hFF, -2, -1, 512, 513, 1};
    vecs[2] = '{TGT_OBM, 8'h02, -2, 10, 256, 257, 1};
    vecs[3] = '{TGT_OBM, 8'h10, 100, -1, 100, 102, 0};
    vecs[4] = '{TGT_PMF, 8'h01, -1, -1, 0, 1, 0};
    vecs[5] = '{TGT_PMF, 8'h7F, 511, -1, 511, 513, 0};

    rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; target_i = TGT_OBM; page_i = 8'h00;
    #22;
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset wen", 32'(vram_wen_o), 32'd0);
    chk("reset ren", 32'(src_ren_o), 32'd0);
    chk("reset selects", 32'({SELECT_obm_o, SELECT_pmf_o}), 32'd0);
    chk("reset vram_address", 32'(vram_address_o), 32'd0);
    chk("reset src_address", 32'(src_address_o), 32'd0);
    @(negedge cpu_clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // abort and start together in IDLE: request is dropped
    @(posedge cpu_clk); #1;
    start_i = 1'b1; abort_i = 1'b1; target_i = TGT_PMF; page_i = 8'h02;
    @(posedge cpu_clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge cpu_clk);
      if (busy_o || src_ren_o || vram_wen_o) seen++;
    end
    chk("abort_beats_start", 32'(seen), 32'd0);

    // asynchronous reset in the middle of XFER k=37
    @(posedge cpu_clk); #1;
    start_i = 1'b1; target_i = TGT_OBM; page_i = 8'h02;
    @(posedge cpu_clk); #1;
    start_i = 1'b0;
    nwr = 0;
    for (int c = 0; c < 38; c++) begin
      @(negedge cpu_clk);
      if (vram_wen_o) nwr++;
      @(posedge cpu_clk); #1;
    end
    #2;
    chk("rst_mid pre wen", 32'(vram_wen_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid wen", 32'(vram_wen_o), 32'd0);
    chk("rst_mid busy", 32'(busy_o), 32'd0);
    chk("rst_mid vram_address", 32'(vram_address_o), 32'd0);
    chk("rst_mid writes_before", 32'(nwr), 32'd37);
    repeat (3) @(negedge cpu_clk);
    rst = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge cpu_clk);
      if (busy_o || vram_wen_o || src_ren_o || done_o) seen++;
    end
    chk("rst_mid no_resume", 32'(seen), 32'd0);

    // back-to-back with start_i held high
    @(posedge cpu_clk); #1;
    start_i = 1'b1; target_i = TGT_OBM; page_i = 8'h02;
    nwr = 0; ndone = 0; d1 = -1; d2 = -1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (d1 >= 0 && cyc >= d1 + 2) start_i = 1'b0;
      @(negedge cpu_clk);
      if (vram_wen_o) nwr++;
      if (done_o) begin
        ndone++;
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
      if (d1 >= 0 && cyc == d1 + 1) chk("b2b idle gap busy", 32'(busy_o), 32'd0);
      if (d1 >= 0 && cyc == d1 + 2) chk("b2b second accept busy", 32'(busy_o), 32'd1);
      if (d2 >= 0 && cyc > d2) break;
      @(posedge cpu_clk); #1;
    end
    start_i = 1'b0;
    chk("b2b done_pulses", 32'(ndone), 32'd2);
    chk("b2b writes", 32'(nwr), 32'd512);
    chk("b2b done_spacing", 32'(d2 - d1), 32'd259);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
